// File: rtl/fft_butterfly.sv
// fft_butterfly: three-stage radix-2 DIT butterfly with twiddle lookup and a 16-butterfly stage counter
module fft_butterfly #(
    parameter int DATA_W = 16,
    parameter int TW_W   = 16,
    parameter int OUT_W  = 18
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [16:0]              real_twiddle_register [32:0],
    input  logic [16:0]              imag_twiddle_register [32:0],
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] a_re,
    input  logic signed [DATA_W-1:0] a_im,
    input  logic signed [DATA_W-1:0] b_re,
    input  logic signed [DATA_W-1:0] b_im,
    input  logic [4:0]               tw_idx,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  x0_re,
    output logic signed [OUT_W-1:0]  x0_im,
    output logic signed [OUT_W-1:0]  x1_re,
    output logic signed [OUT_W-1:0]  x1_im,
    output logic                     stage_done
);
    localparam int PW = DATA_W + TW_W + 1;
    localparam int SW = PW + 18;
    localparam logic signed [SW-1:0] SCALE = SW'(67109);

    logic                     adv, hs;
    logic signed [SW-1:0]     sr, si;
    logic signed [OUT_W-1:0]  tr, ti;
    logic                     v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic signed [DATA_W-1:0] ar1_q, ar1_d, ai1_q, ai1_d, br1_q, br1_d, bi1_q, bi1_d;
    logic signed [TW_W-1:0]   wr1_q, wr1_d, wi1_q, wi1_d;
    logic signed [DATA_W-1:0] ar2_q, ar2_d, ai2_q, ai2_d;
    logic signed [PW-1:0]     pr2_q, pr2_d, pi2_q, pi2_d;
    logic signed [OUT_W-1:0]  x0r_q, x0r_d, x0i_q, x0i_d, x1r_q, x1r_d, x1i_q, x1i_d;
    logic [3:0]               cnt_q, cnt_d;
    logic                     done_q, done_d;

    // Table entries are wider than the twiddle operand; the top bit is ignored
    logic [32:0] unused_msb;
    for (genvar g = 0; g < 33; g++) begin : g_unused
        assign unused_msb[g] = real_twiddle_register[g][16] ^ imag_twiddle_register[g][16];
    end

    // Next state: every stage moves together on adv; the scale by 67109 >>> 26 approximates /1000 with floor
    always_comb begin
        adv    = out_ready | ~v3_q;
        hs     = v3_q & out_ready;
        v1_d   = adv ? in_valid : v1_q;
        ar1_d  = adv ? a_re : ar1_q;
        ai1_d  = adv ? a_im : ai1_q;
        br1_d  = adv ? b_re : br1_q;
        bi1_d  = adv ? b_im : bi1_q;
        wr1_d  = adv ? real_twiddle_register[{1'b0, tw_idx}][TW_W-1:0] : wr1_q;
        wi1_d  = adv ? imag_twiddle_register[{1'b0, tw_idx}][TW_W-1:0] : wi1_q;
        v2_d   = adv ? v1_q : v2_q;
        ar2_d  = adv ? ar1_q : ar2_q;
        ai2_d  = adv ? ai1_q : ai2_q;
        pr2_d  = adv ? PW'(br1_q) * PW'(wr1_q) - PW'(bi1_q) * PW'(wi1_q) : pr2_q;
        pi2_d  = adv ? PW'(br1_q) * PW'(wi1_q) + PW'(bi1_q) * PW'(wr1_q) : pi2_q;
        sr     = SW'(pr2_q) * SCALE;
        si     = SW'(pi2_q) * SCALE;
        tr     = OUT_W'(sr >>> 26);
        ti     = OUT_W'(si >>> 26);
        v3_d   = adv ? v2_q : v3_q;
        x0r_d  = adv ? OUT_W'(ar2_q) + tr : x0r_q;
        x0i_d  = adv ? OUT_W'(ai2_q) + ti : x0i_q;
        x1r_d  = adv ? OUT_W'(ar2_q) - tr : x1r_q;
        x1i_d  = adv ? OUT_W'(ai2_q) - ti : x1i_q;
        cnt_d  = cnt_q + 4'(hs);
        done_d = hs & (cnt_q == 4'd15);
    end

    // State registers with synchronous clear of valids, data and counter
    always_ff @(posedge clk) begin
        if (reset) begin
            {v1_q, v2_q, v3_q, done_q} <= '0;
            {ar1_q, ai1_q, br1_q, bi1_q, wr1_q, wi1_q} <= '0;
            {ar2_q, ai2_q, pr2_q, pi2_q} <= '0;
            {x0r_q, x0i_q, x1r_q, x1i_q} <= '0;
            cnt_q <= '0;
        end else begin
            {v1_q, v2_q, v3_q, done_q} <= {v1_d, v2_d, v3_d, done_d};
            {ar1_q, ai1_q, br1_q, bi1_q, wr1_q, wi1_q} <= {ar1_d, ai1_d, br1_d, bi1_d, wr1_d, wi1_d};
            {ar2_q, ai2_q, pr2_q, pi2_q} <= {ar2_d, ai2_d, pr2_d, pi2_d};
            {x0r_q, x0i_q, x1r_q, x1i_q} <= {x0r_d, x0i_d, x1r_d, x1i_d};
            cnt_q <= cnt_d;
        end
    end

    assign in_ready   = adv;
    assign out_valid  = v3_q;
    assign x0_re      = x0r_q;
    assign x0_im      = x0i_q;
    assign x1_re      = x1r_q;
    assign x1_im      = x1i_q;
    assign stage_done = done_q;
endmodule
